// File: rtl/multicycle_control_if.sv
// Bus between the multicycle control unit and the instruction register / datapath.
// The control unit connects through the slave modport; the datapath side uses master.
interface multicycle_control_if;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       mem_ready;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       ALUSrc;
    logic [1:0] AluOp;
    logic       illegal;
    logic [2:0] state;

    modport slave (
        input  opcode, func3, mem_ready,
        output ir_write, pc_write, pc_write_cond, mem_read, mem_write,
               reg_write, mem_to_reg, ALUSrc, AluOp, illegal, state
    );

    modport master (
        output opcode, func3, mem_ready,
        input  ir_write, pc_write, pc_write_cond, mem_read, mem_write,
               reg_write, mem_to_reg, ALUSrc, AluOp, illegal, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle main control FSM for the RV32 core: FETCH/DECODE/EXEC/MEM/WB/TRAP.
// Optional macro ITYPE_ALU_EN makes ADDI (opcode 0010011, func3 000) a legal class.
module multicycle_control (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_if.slave    bus
);
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FUNC3_W  = 3;

    localparam logic [OPCODE_W-1:0] OP_R      = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);
`ifdef ITYPE_ALU_EN
    localparam logic [OPCODE_W-1:0] OP_IALU   = OPCODE_W'(7'b0010011);
    localparam logic [FUNC3_W-1:0]  F3_ADDI   = FUNC3_W'(3'b000);
`endif

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE, CLS_R, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_IALU
    } cls_t;

    state_t state_q, state_d;
    cls_t   cls_q, dec_cls;

    // Instruction class decode, only meaningful while in DECODE
    always_comb begin
        dec_cls = CLS_NONE;
        case (bus.opcode)
            OP_R:      dec_cls = CLS_R;
            OP_LOAD:   dec_cls = CLS_LOAD;
            OP_STORE:  dec_cls = CLS_STORE;
            OP_BRANCH: dec_cls = CLS_BRANCH;
`ifdef ITYPE_ALU_EN
            OP_IALU:   if (bus.func3 == F3_ADDI) dec_cls = CLS_IALU;
`endif
            default:   dec_cls = CLS_NONE;
        endcase
    end

`ifndef ITYPE_ALU_EN
    logic unused_func3;
    assign unused_func3 = ^bus.func3;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            cls_q   <= CLS_NONE;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) cls_q <= dec_cls;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (bus.mem_ready) state_d = DECODE;
            DECODE: state_d = (dec_cls == CLS_NONE) ? TRAP : EXEC;
            EXEC: begin
                case (cls_q)
                    CLS_R, CLS_IALU:     state_d = WB;
                    CLS_LOAD, CLS_STORE: state_d = MEM;
                    default:             state_d = FETCH;
                endcase
            end
            MEM:    if (bus.mem_ready) state_d = (cls_q == CLS_LOAD) ? WB : FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Outputs are forced low during reset so an aborted write cannot linger
    always_comb begin
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.reg_write     = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.ALUSrc        = 1'b0;
        bus.AluOp         = 2'b00;
        bus.illegal       = 1'b0;
        if (!reset) begin
            // ALU controls hold their EXEC value through MEM and WB
            if (state_q == EXEC || state_q == MEM || state_q == WB) begin
                case (cls_q)
                    CLS_R:      bus.AluOp  = 2'b10;
                    CLS_BRANCH: bus.AluOp  = 2'b01;
                    CLS_LOAD, CLS_STORE, CLS_IALU: bus.ALUSrc = 1'b1;
                    default:    bus.AluOp  = 2'b00;
                endcase
            end
            case (state_q)
                FETCH: begin
                    bus.mem_read = 1'b1;
                    bus.ir_write = bus.mem_ready;
                    bus.pc_write = bus.mem_ready;
                end
                EXEC:  bus.pc_write_cond = (cls_q == CLS_BRANCH);
                MEM: begin
                    bus.mem_read  = (cls_q == CLS_LOAD);
                    bus.mem_write = (cls_q == CLS_STORE);
                end
                WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = (cls_q == CLS_LOAD);
                end
                TRAP:    bus.illegal = 1'b1;
                default: bus.illegal = 1'b0;
            endcase
        end
    end

    assign bus.state = state_q;
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle main control unit for the RV32 core. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the `ALUSrc` and `AluOp` inputs of the ALU control block, plus all register-file, memory and PC enables. It sits between the instruction register and the datapath, and stalls on a single memory-ready handshake.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  7  instruction bits [6:0] from the instruction register.
- `func3`  in  3  instruction bits [14:12].
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `ir_write`  out  1  load instruction register.
- `pc_write`  out  1  unconditional PC update (PC+4).
- `pc_write_cond`  out  1  PC takes branch target if ALU `zero`.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `reg_write`  out  1  register-file write enable.
- `mem_to_reg`  out  1  writeback source: 1 = memory data, 0 = ALU result.
- `ALUSrc`  out  1  ALU operand 2: 1 = immediate, 0 = rs2.
- `AluOp`  out  2  00 = load/store (ADD), 01 = branch (SUB), 10 = R-type.
- `illegal`  out  1  unsupported opcode trap indication.
- `state`  out  3  current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 are unreachable and go to FETCH.
- Instruction classes are latched from `opcode` on the DECODE→EXEC edge. After DECODE, `opcode` and `func3` are don't-care.
  - R = 0110011
  - LOAD = 0000011
  - STORE = 0100011
  - BRANCH = 1100011
  - IALU = 0010011, only when the config macro is enabled
- Transitions:
  - FETCH: stays while `!mem_ready`, then → DECODE.
  - DECODE: a legal class → EXEC, otherwise → TRAP.
  - EXEC: R/IALU → WB, LOAD/STORE → MEM, BRANCH → FETCH.
  - MEM: stays while `!mem_ready`. LOAD → WB, STORE → FETCH.
  - WB → FETCH.
  - TRAP → FETCH.
- Output decode:
  - FETCH: `mem_read`=1; `ir_write` = `pc_write` = `mem_ready` (Mealy on `mem_ready` only).
  - EXEC:
    - R: `ALUSrc`=0, `AluOp`=10.
    - LOAD/STORE/IALU: `ALUSrc`=1, `AluOp`=00.
    - BRANCH: `ALUSrc`=0, `AluOp`=01, `pc_write_cond`=1.
  - MEM: LOAD `mem_read`=1, STORE `mem_write`=1.
  - WB: `reg_write`=1; `mem_to_reg`=1 for LOAD, 0 otherwise.
  - TRAP: `illegal`=1.
- `ALUSrc` and `AluOp` hold their EXEC values through MEM and WB. They are 0/00 in FETCH, DECODE and TRAP.
- All outputs not listed for a state are 0.

## Timing
- While `reset`=1: `state`=FETCH (0) and every output is 0, including `mem_read`. The first FETCH request occurs in the first cycle after release.
- Reset asserted mid-instruction aborts immediately (asynchronous). No partial write may follow: `reg_write` and `mem_write` drop in the same cycle.
- Latency with `mem_ready`=1 throughout:
  - BRANCH: 3 cycles.
  - STORE, R, IALU: 4 cycles.
  - LOAD: 5 cycles.
  - Illegal opcode: 3 cycles (FETCH, DECODE, TRAP).
- Each low cycle of `mem_ready` in FETCH or MEM adds exactly one cycle.
- `illegal` is high for exactly one cycle per illegal instruction.
- `mem_ready` is ignored outside FETCH and MEM.

## Configuration
- `ITYPE_ALU_EN` defined:
  - Opcode 0010011 is legal only with `func3`=000 (ADDI). It runs EXEC with `ALUSrc`=1, `AluOp`=00, then WB with `mem_to_reg`=0.
  - Opcode 0010011 with any other `func3` → TRAP.
  - `AluOp`=10 is never used for I-type, because immediate bits would alias `func7` in ALU control.
- `ITYPE_ALU_EN` undefined: opcode 0010011 → TRAP.

## Test plan
- Reset released, `mem_ready`=1, `opcode`=0110011 → states 0,1,2,4,0. `AluOp`=10 in cycles 3–4; `reg_write`=1 only in cycle 4 with `mem_to_reg`=0.
- LOAD with `mem_ready` low for 2 cycles in MEM → `mem_read`=1 for 3 MEM cycles. WB follows with `reg_write`=1 and `mem_to_reg`=1. Total 7 cycles.
- STORE then BRANCH back-to-back:
  - STORE: `mem_write` high exactly one cycle, `ALUSrc`=1, `AluOp`=00.
  - BRANCH: EXEC has `AluOp`=01, `pc_write_cond`=1, and returns to FETCH with no `reg_write`.
- `opcode`=1111111 → `illegal`=1 for one cycle in state 5, then FETCH. No memory or register write occurs.
- Reset asserted during WB of an R-type → `reg_write` falls in the same cycle and `state`=0. The first post-reset cycle is FETCH with `mem_read`=1.
- `opcode`=0010011: with `func3`=000 and `ITYPE_ALU_EN` defined → `ALUSrc`=1, `AluOp`=00, WB writes. With `func3`=001, or with the macro undefined → TRAP.
